// File: rtl/fulladder_halfadder_if.sv
// rtl/fulladder_halfadder_if.sv - operand/result bundle for the full-adder cell
interface fulladder_halfadder_if;
    logic en;
    logic x;
    logic y;
    logic z;
    logic sum;
    logic carry;
    logic sum_q;
    logic carry_q;
    logic valid_q;

    modport master (
        output en, x, y, z,
        input  sum, carry, sum_q, carry_q, valid_q
    );

    modport slave (
        input  en, x, y, z,
        output sum, carry, sum_q, carry_q, valid_q
    );
endinterface

// File: rtl/fulladder_halfadder.sv
// rtl/fulladder_halfadder.sv - 1-bit full adder from two half adders, with optional output register
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fulladder_halfadder #(
    parameter int unsigned REG_OUT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fulladder_halfadder_if.slave       bus
);
    logic s1;
    logic c1;
    logic c2;
    logic sum_w;
    logic carry_w;

    half_adder ha1 (
        .a (bus.x),
        .b (bus.y),
        .s (s1),
        .c (c1)
    );

    half_adder ha2 (
        .a (s1),
        .b (bus.z),
        .s (sum_w),
        .c (c2)
    );

    assign carry_w   = c1 | c2;
    assign bus.sum   = sum_w;
    assign bus.carry = carry_w;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic sum_r;
            logic carry_r;
            logic valid_r;

            // sum/carry hold when en is low; valid marks only the cycle after a capture
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_r   <= 1'b0;
                    carry_r <= 1'b0;
                    valid_r <= 1'b0;
                end else if (bus.en) begin
                    sum_r   <= sum_w;
                    carry_r <= carry_w;
                    valid_r <= 1'b1;
                end else begin
                    valid_r <= 1'b0;
                end
            end

            assign bus.sum_q   = sum_r;
            assign bus.carry_q = carry_r;
            assign bus.valid_q = valid_r;
        end else begin : g_noreg
            assign bus.sum_q   = 1'b0;
            assign bus.carry_q = 1'b0;
            assign bus.valid_q = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_fulladder_halfadder.sv
// tb/tb_fulladder_halfadder.sv - directed self-checking bench for fulladder_halfadder
module tb_fulladder_halfadder;
    logic clk;
    logic rst_n;
    logic clk_run;
    int   n_cmp;
    int   n_fail;

    fulladder_halfadder_if ifc ();

    fulladder_halfadder #(.REG_OUT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // clock only toggles while clk_run is set, so clockless phases see clk held at 0
    initial clk = 1'b0;
    always begin
        #5;
        clk = clk_run ? ~clk : 1'b0;
    end

    initial begin
        #50000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] sum_tab;
        logic [7:0] carry_tab;
        logic [2:0] v;
        logic [1:0] arith;

        sum_tab   = 8'h96;
        carry_tab = 8'hE8;
        n_cmp     = 0;
        n_fail    = 0;
        clk_run   = 1'b0;
        rst_n     = 1'b1;
        ifc.en    = 1'b0;
        ifc.x     = 1'b0;
        ifc.y     = 1'b0;
        ifc.z     = 1'b0;
        #10;

        // exhaustive combinational sweep, clock stopped
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {ifc.x, ifc.y, ifc.z} = v;
            #10;
            chk($sformatf("comb_sum_%0d", i), ifc.sum, sum_tab[i]);
            chk($sformatf("comb_carry_%0d", i), ifc.carry, carry_tab[i]);
            arith = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            chk2($sformatf("arith_%0d", i), {ifc.carry, ifc.sum}, arith);
        end

        // reset held with all-ones inputs
        ifc.x = 1'b1; ifc.y = 1'b1; ifc.z = 1'b1;
        rst_n = 1'b0;
        #10;
        chk("rst_sum_q", ifc.sum_q, 1'b0);
        chk("rst_carry_q", ifc.carry_q, 1'b0);
        chk("rst_valid_q", ifc.valid_q, 1'b0);
        chk("rst_sum", ifc.sum, 1'b1);
        chk("rst_carry", ifc.carry, 1'b1);

        // capture 1+0+1 -> carry 1, sum 0
        clk_run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        ifc.x = 1'b1; ifc.y = 1'b0; ifc.z = 1'b1;
        ifc.en = 1'b1;
        @(posedge clk); #1;
        chk("cap_sum_q", ifc.sum_q, 1'b0);
        chk("cap_carry_q", ifc.carry_q, 1'b1);
        chk("cap_valid_q", ifc.valid_q, 1'b1);

        // en low with changed inputs: values held, valid drops
        @(negedge clk);
        ifc.en = 1'b0;
        ifc.x = 1'b1; ifc.y = 1'b1; ifc.z = 1'b1;
        @(posedge clk); #1;
        chk("hold_sum_q", ifc.sum_q, 1'b0);
        chk("hold_carry_q", ifc.carry_q, 1'b1);
        chk("hold_valid_q", ifc.valid_q, 1'b0);

        // capture 1+0+0 -> sum 1, then async reset between edges
        @(negedge clk);
        ifc.en = 1'b1;
        ifc.x = 1'b1; ifc.y = 1'b0; ifc.z = 1'b0;
        @(posedge clk); #1;
        chk("cap2_sum_q", ifc.sum_q, 1'b1);
        chk("cap2_carry_q", ifc.carry_q, 1'b0);
        chk("cap2_valid_q", ifc.valid_q, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_sum_q", ifc.sum_q, 1'b0);
        chk("async_valid_q", ifc.valid_q, 1'b0);
        chk("async_sum", ifc.sum, 1'b1);

        // en high across an edge while in reset: still cleared
        @(posedge clk); #1;
        chk("inrst_sum_q", ifc.sum_q, 1'b0);
        chk("inrst_valid_q", ifc.valid_q, 1'b0);

        // first capture after release: 1+1+0 -> carry 1, sum 0
        @(negedge clk);
        rst_n = 1'b1;
        ifc.x = 1'b1; ifc.y = 1'b1; ifc.z = 1'b0;
        @(posedge clk); #1;
        chk("rel_sum_q", ifc.sum_q, 1'b0);
        chk("rel_carry_q", ifc.carry_q, 1'b1);
        chk("rel_valid_q", ifc.valid_q, 1'b1);

        // clockless: clk, rst_n, en all tied low
        clk_run = 1'b0;
        #20;
        rst_n  = 1'b0;
        ifc.en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(7 - i);
            {ifc.x, ifc.y, ifc.z} = v;
            #10;
            chk($sformatf("nclk_sum_%0d", 7 - i), ifc.sum, sum_tab[7 - i]);
            chk($sformatf("nclk_carry_%0d", 7 - i), ifc.carry, carry_tab[7 - i]);
        end
        chk("nclk_valid_q", ifc.valid_q, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
